// File: rtl/ins_sincos.sv
// ins_sincos: float32 angle (radians) -> float32 sin/cos.
// Angle is converted to Q3.13 and folded into +/-pi/2. An iterative rotation-mode
// CORDIC then produces Q1.14 cos (x) and sin (y), which are converted back to float32.
// Optional macro SINCOS_RANGE_ERR_EN: NaN/Inf/|angle|>pi return quiet NaN on both outputs
// instead of saturating the angle to +/-pi.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   en             start request, sampled only in IDLE
//   angle          float32 angle in radians
//   sin_out        float32 sin(angle), registered
//   cos_out        float32 cos(angle), registered
//   sincos_finish  one-cycle done pulse; outputs valid from this cycle
module ins_sincos #(
  parameter int unsigned ITER = 14,
  parameter int unsigned DW   = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] angle,
  output logic [31:0] sin_out,
  output logic [31:0] cos_out,
  output logic        sincos_finish
);

  localparam int unsigned CW = 5;
  localparam logic signed [DW-1:0] PI_Q  = DW'(25736);  // 0x6488, pi in Q3.13
  localparam logic signed [DW-1:0] HPI_Q = DW'(12868);  // 0x3244, pi/2 in Q3.13
  localparam logic signed [DW-1:0] K_Q   = DW'(9949);   // 0x26DD, CORDIC gain comp in Q1.14
  localparam logic [31:0]          QNAN  = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_IN,
    S_FOLD,
    S_ROT,
    S_NORM,
    S_FINISH
  } state_t;

  state_t                state, state_n;
  logic [31:0]           angle_q, angle_n;
  logic signed [DW-1:0]  x_q, x_n, y_q, y_n, z_q, z_n;
  logic                  neg_q, neg_n;
  logic                  err_q, err_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [31:0]           sin_n, cos_n;
  logic                  fin_n;

  // conversion / rotation temporaries
  logic [7:0]            exp_w;
  logic [23:0]           mant24;
  logic [DW-1:0]         mag;
  logic                  sat;
  logic                  is_nan;
  logic signed [DW-1:0]  xs, ys, xf, yf;

  // round(atan(2^-i) * 8192)
  function automatic logic signed [DW-1:0] atan_rom(input logic [CW-1:0] i);
    case (i)
      5'd0:    return DW'(16'h1922);
      5'd1:    return DW'(16'h0ED6);
      5'd2:    return DW'(16'h07D7);
      5'd3:    return DW'(16'h03FB);
      5'd4:    return DW'(16'h01FF);
      5'd5:    return DW'(16'h0100);
      5'd6:    return DW'(16'h0080);
      5'd7:    return DW'(16'h0040);
      5'd8:    return DW'(16'h0020);
      5'd9:    return DW'(16'h0010);
      5'd10:   return DW'(16'h0008);
      5'd11:   return DW'(16'h0004);
      5'd12:   return DW'(16'h0002);
      5'd13:   return DW'(16'h0001);
      default: return '0;
    endcase
  endfunction

  // Q1.14 signed -> float32, exact (magnitude never exceeds 24 significant bits)
  function automatic logic [31:0] to_f32(input logic signed [DW-1:0] v);
    logic [DW-1:0] m;
    logic [4:0]    pos;
    logic [22:0]   frac;
    logic [7:0]    e;
    m   = $unsigned(v[DW-1] ? -v : v);
    pos = '0;
    for (int k = 0; k < int'(DW); k++) begin
      if (m[k]) pos = 5'(k);
    end
    // leading one is shifted out past bit 22, leaving the fraction left-justified
    frac = 23'(m) << (5'd23 - pos);
    e    = 8'd113 + {3'b000, pos};
    if (m == '0) return 32'h0000_0000;
    return {v[DW-1], e, frac};
  endfunction

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      angle_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      z_q           <= '0;
      neg_q         <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      sin_out       <= '0;
      cos_out       <= '0;
      sincos_finish <= 1'b0;
    end else begin
      state         <= state_n;
      angle_q       <= angle_n;
      x_q           <= x_n;
      y_q           <= y_n;
      z_q           <= z_n;
      neg_q         <= neg_n;
      err_q         <= err_n;
      cnt_q         <= cnt_n;
      sin_out       <= sin_n;
      cos_out       <= cos_n;
      sincos_finish <= fin_n;
    end
  end

  // next-state and datapath
  always_comb begin
    state_n = state;
    angle_n = angle_q;
    x_n     = x_q;
    y_n     = y_q;
    z_n     = z_q;
    neg_n   = neg_q;
    err_n   = err_q;
    cnt_n   = cnt_q;
    sin_n   = sin_out;
    cos_n   = cos_out;
    fin_n   = 1'b0;

    exp_w   = angle_q[30:23];
    mant24  = {1'b1, angle_q[22:0]};
    mag     = '0;
    sat     = 1'b0;
    is_nan  = (exp_w == 8'hFF) && (angle_q[22:0] != 23'd0);
    xs      = x_q >>> cnt_q;
    ys      = y_q >>> cnt_q;
    xf      = neg_q ? -x_q : x_q;
    yf      = neg_q ? -y_q : y_q;

    case (state)
      S_IDLE: begin
        if (en) begin
          angle_n = angle;
          state_n = S_CONV_IN;
        end
      end

      S_CONV_IN: begin
        // magnitude = mant24 * 2^(exp-137), truncated; exp < 114 underflows to 0
        if (exp_w >= 8'd129) begin
          sat = 1'b1;
        end else if (exp_w >= 8'd114) begin
          mag = DW'(mant24 >> (8'd137 - exp_w));
          sat = ($signed(mag) > PI_Q);
        end
`ifdef SINCOS_RANGE_ERR_EN
        err_n = sat | is_nan;
        if (sat) z_n = '0;
        else     z_n = angle_q[31] ? -$signed(mag) : $signed(mag);
`else
        err_n = 1'b0;
        if (sat) z_n = (is_nan || !angle_q[31]) ? PI_Q : -PI_Q;
        else     z_n = angle_q[31] ? -$signed(mag) : $signed(mag);
`endif
        state_n = S_FOLD;
      end

      S_FOLD: begin
        // outside +/-pi/2 rotate by pi and negate the result later
        x_n   = K_Q;
        y_n   = '0;
        cnt_n = '0;
        if (z_q > HPI_Q) begin
          z_n   = z_q - PI_Q;
          neg_n = 1'b1;
        end else if (z_q < -HPI_Q) begin
          z_n   = z_q + PI_Q;
          neg_n = 1'b1;
        end else begin
          neg_n = 1'b0;
        end
        state_n = S_ROT;
      end

      S_ROT: begin
        if (!err_q) begin
          if (!z_q[DW-1]) begin
            x_n = x_q - ys;
            y_n = y_q + xs;
            z_n = z_q - atan_rom(cnt_q);
          end else begin
            x_n = x_q + ys;
            y_n = y_q - xs;
            z_n = z_q + atan_rom(cnt_q);
          end
        end
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_n = S_NORM;
      end

      S_NORM: begin
        if (err_q) begin
          sin_n = QNAN;
          cos_n = QNAN;
        end else begin
          sin_n = to_f32(yf);
          cos_n = to_f32(xf);
        end
        fin_n   = 1'b1;
        state_n = S_FINISH;
      end

      S_FINISH: begin
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ins_sincos.sv
// Scoreboard bench for ins_sincos: expected sin/cos are pushed when a job is
// issued and popped when sincos_finish is observed.
module tb_ins_sincos;

  localparam real TOL    = 1.0 / 2048.0;
  localparam real PI_SAT = 25736.0 / 8192.0;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] angle;
  logic [31:0] sin_out;
  logic [31:0] cos_out;
  logic        sincos_finish;

  int pass_cnt  = 0;
  int total_cnt = 0;

  real exp_sin_q[$];
  real exp_cos_q[$];
  bit  exp_nan_q[$];

  ins_sincos dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .angle         (angle),
    .sin_out       (sin_out),
    .cos_out       (cos_out),
    .sincos_finish (sincos_finish)
  );

  always #5 clk = ~clk;

  function automatic real rabs(input real r);
    return (r < 0.0) ? -r : r;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // angle the unit actually rotates by: Q3.13 truncation, saturation at +/-pi
  function automatic real quant_angle(input logic [31:0] a);
    real q;
    if (a[30:23] == 8'hFF) return (a[22:0] != 23'd0 || !a[31]) ? PI_SAT : -PI_SAT;
    q = $floor(rabs(f2r(a)) * 8192.0) / 8192.0;
    if (q > PI_SAT) q = PI_SAT;
    return a[31] ? -q : q;
  endfunction

  function automatic bit range_err(input logic [31:0] a);
    if (a[30:23] == 8'hFF) return 1'b1;
    return ($floor(rabs(f2r(a)) * 8192.0) > 25736.0);
  endfunction

  task automatic push_expect(input logic [31:0] a);
    real th;
    th = quant_angle(a);
`ifdef SINCOS_RANGE_ERR_EN
    exp_nan_q.push_back(range_err(a));
`else
    exp_nan_q.push_back(1'b0);
`endif
    exp_sin_q.push_back($sin(th));
    exp_cos_q.push_back($cos(th));
  endtask

  task automatic issue(input logic [31:0] a);
    push_expect(a);
    @(negedge clk);
    angle = a;
    en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en    = 1'b0;
  endtask

  task automatic wait_finish(input int max_cyc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max_cyc) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (sincos_finish) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    en    = 1'b0;
    angle = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (sin_out !== 32'h0) $display("FAIL reset_sin got %h want 00000000", sin_out); else pass_cnt++;
    total_cnt++;
    if (cos_out !== 32'h0) $display("FAIL reset_cos got %h want 00000000", cos_out); else pass_cnt++;
    total_cnt++;
    if (sincos_finish !== 1'b0) $display("FAIL reset_finish got %b want 0", sincos_finish); else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_latency();
    int cyc;
    bit seen;
    real es, ec;
    bit  enan;
    issue(32'h0000_0000);
    wait_finish(40, cyc, seen);
    es = exp_sin_q.pop_front(); ec = exp_cos_q.pop_front(); enan = exp_nan_q.pop_front();
    total_cnt++;
    if (!seen || cyc != 17) $display("FAIL latency got seen=%0b cycles=%0d want seen=1 cycles=17", seen, cyc);
    else pass_cnt++;
    total_cnt++;
    if (enan || rabs(f2r(sin_out) - es) > TOL) $display("FAIL zero_sin got %h want %f", sin_out, es);
    else pass_cnt++;
    total_cnt++;
    if (enan || rabs(f2r(cos_out) - ec) > TOL) $display("FAIL zero_cos got %h want %f", cos_out, ec);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (sincos_finish !== 1'b0) $display("FAIL finish_width got %b want 0 one cycle later", sincos_finish);
    else pass_cnt++;
  endtask

  // in-range angles, including the fold path and underflow to zero
  task automatic test_angles();
    logic [31:0] tbl [8];
    int cyc;
    bit seen;
    real es, ec;
    bit  enan;
    tbl = '{32'h3FC9_0FDB, 32'hBF06_0A92, 32'h4020_0000, 32'hC020_0000,
            32'h3F00_0000, 32'h3F49_0FDB, 32'h3800_0000, 32'h0000_0001};
    foreach (tbl[i]) begin
      issue(tbl[i]);
      wait_finish(40, cyc, seen);
      es = exp_sin_q.pop_front(); ec = exp_cos_q.pop_front(); enan = exp_nan_q.pop_front();
      total_cnt++;
      if (!seen || enan || rabs(f2r(sin_out) - es) > TOL)
        $display("FAIL angle_sin angle=%h seen=%0b got %h (%f) want %f", tbl[i], seen, sin_out, f2r(sin_out), es);
      else pass_cnt++;
      total_cnt++;
      if (!seen || enan || rabs(f2r(cos_out) - ec) > TOL)
        $display("FAIL angle_cos angle=%h seen=%0b got %h (%f) want %f", tbl[i], seen, cos_out, f2r(cos_out), ec);
      else pass_cnt++;
      if (tbl[i] == 32'h4020_0000) begin
        total_cnt++;
        if (cos_out[31] !== 1'b1) $display("FAIL fold_cos_sign got %b want 1", cos_out[31]);
        else pass_cnt++;
      end
    end
  endtask

  // out-of-range and boundary angles
  task automatic test_range();
    logic [31:0] tbl [6];
    int cyc;
    bit seen;
    real es, ec;
    bit  enan;
    tbl = '{32'h4080_0000, 32'hC080_0000, 32'h7FC0_0000, 32'hFF80_0000,
            32'h4049_1000, 32'h4049_1200};
    foreach (tbl[i]) begin
      issue(tbl[i]);
      wait_finish(40, cyc, seen);
      es = exp_sin_q.pop_front(); ec = exp_cos_q.pop_front(); enan = exp_nan_q.pop_front();
      if (enan) begin
        total_cnt++;
        if (!seen || sin_out !== 32'h7FC0_0000) $display("FAIL range_sin angle=%h got %h want 7fc00000", tbl[i], sin_out);
        else pass_cnt++;
        total_cnt++;
        if (!seen || cos_out !== 32'h7FC0_0000) $display("FAIL range_cos angle=%h got %h want 7fc00000", tbl[i], cos_out);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (!seen || rabs(f2r(sin_out) - es) > TOL)
          $display("FAIL range_sin angle=%h seen=%0b got %h want %f", tbl[i], seen, sin_out, es);
        else pass_cnt++;
        total_cnt++;
        if (!seen || rabs(f2r(cos_out) - ec) > TOL)
          $display("FAIL range_cos angle=%h seen=%0b got %h want %f", tbl[i], seen, cos_out, ec);
        else pass_cnt++;
      end
      total_cnt++;
      if (cyc != 17) $display("FAIL range_latency angle=%h got %0d want 17", tbl[i], cyc);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [2];
    int cyc [2];
    bit seen;
    real es, ec;
    bit  enan;
    a = '{32'h3F06_0A92, 32'hBFC0_0000};
    push_expect(a[0]);
    push_expect(a[1]);
    @(negedge clk);
    angle = a[0];
    en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    angle = a[1];
    for (int j = 0; j < 2; j++) begin
      wait_finish(40, cyc[j], seen);
      if (j == 1) en = 1'b0;
      es = exp_sin_q.pop_front(); ec = exp_cos_q.pop_front(); enan = exp_nan_q.pop_front();
      total_cnt++;
      if (!seen || enan || rabs(f2r(sin_out) - es) > TOL)
        $display("FAIL b2b_sin job=%0d seen=%0b got %h want %f", j, seen, sin_out, es);
      else pass_cnt++;
      total_cnt++;
      if (!seen || enan || rabs(f2r(cos_out) - ec) > TOL)
        $display("FAIL b2b_cos job=%0d seen=%0b got %h want %f", j, seen, cos_out, ec);
      else pass_cnt++;
    end
    en = 1'b0;
    total_cnt++;
    if (cyc[0] != 17 || cyc[1] != 19)
      $display("FAIL b2b_spacing got %0d,%0d want 17,19", cyc[0], cyc[1]);
    else pass_cnt++;
    wait_finish(30, cyc[0], seen);
    total_cnt++;
    if (seen) $display("FAIL b2b_extra_job got finish after %0d cycles want none", cyc[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    bit seen;
    @(negedge clk);
    angle = 32'h3F00_0000;
    en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en    = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    total_cnt++;
    if (sin_out !== 32'h0) $display("FAIL midrst_sin got %h want 00000000", sin_out); else pass_cnt++;
    total_cnt++;
    if (cos_out !== 32'h0) $display("FAIL midrst_cos got %h want 00000000", cos_out); else pass_cnt++;
    total_cnt++;
    if (sincos_finish !== 1'b0) $display("FAIL midrst_finish got %b want 0", sincos_finish); else pass_cnt++;
    wait_finish(30, cyc, seen);
    total_cnt++;
    if (seen) $display("FAIL midrst_no_pulse got finish after %0d cycles want none", cyc);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_angles();
    test_range();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
